// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: command/response bundle between the SPI front end and the RAM controller
interface spi_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();
  localparam int PL_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  logic [PL_WIDTH+1:0]   din;
  logic                  rx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  addr_err;
  logic                  rd_overrun;
  modport master (output din, rx_valid, tx_ready, input dout, tx_valid, addr_err, rd_overrun);
  modport slave  (input din, rx_valid, tx_ready, output dout, tx_valid, addr_err, rd_overrun);
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoded single-port RAM with auto-increment pointers and sticky error flags
module spi_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter bit AUTO_INC   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  spi_ram_ctrl_if.slave bus
);
  localparam int PL_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [1:0]            op;
  logic [PL_WIDTH-1:0]   pl;
  logic                  set_wr, wr_cmd, set_rd, rd_cmd, rd_acc, wr_oob, rd_oob;
  assign op     = bus.din[PL_WIDTH+1:PL_WIDTH];
  assign pl     = bus.din[PL_WIDTH-1:0];
  assign set_wr = bus.rx_valid && op == 2'b00;
  assign wr_cmd = bus.rx_valid && op == 2'b01;
  assign set_rd = bus.rx_valid && op == 2'b10;
  assign rd_cmd = bus.rx_valid && op == 2'b11;
  assign rd_acc = rd_cmd && (!bus.tx_valid || bus.tx_ready);
  assign wr_oob = {1'b0, wr_ptr} >= DEPTH_W;
  assign rd_oob = {1'b0, rd_ptr} >= DEPTH_W;
  // out-of-range pointers are parked; in-range ones wrap at DEPTH-1
  assign wr_nxt = wr_oob ? wr_ptr : ({1'b0, wr_ptr} == LAST_W) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt = rd_oob ? rd_ptr : ({1'b0, rd_ptr} == LAST_W) ? '0 : rd_ptr + 1'b1;
  always_ff @(posedge clk)
    if (wr_cmd && !wr_oob) mem[wr_ptr] <= pl[DATA_WIDTH-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.dout       <= '0;
      bus.tx_valid   <= 1'b0;
      bus.addr_err   <= 1'b0;
      bus.rd_overrun <= 1'b0;
    end else begin
      if (set_wr) wr_ptr <= pl[ADDR_WIDTH-1:0];
      else if (wr_cmd && AUTO_INC) wr_ptr <= wr_nxt;
      if (set_rd) rd_ptr <= pl[ADDR_WIDTH-1:0];
      else if (rd_acc && AUTO_INC) rd_ptr <= rd_nxt;
      if ((wr_cmd && wr_oob) || (rd_acc && rd_oob)) bus.addr_err <= 1'b1;
      if (rd_cmd && !rd_acc) bus.rd_overrun <= 1'b1;
      if (rd_acc) begin
        bus.dout     <= rd_oob ? '0 : mem[rd_ptr];
        bus.tx_valid <= 1'b1;
      end else if (bus.tx_ready) bus.tx_valid <= 1'b0;
    end
  end
endmodule
